reaction_race_fsm: RTL and testbench
====================================

// Module: reaction_race_fsm
// PURPOSE
//  Multi-player successor to the single-button reaction timer FSM. Start button arms a
//  round with a pseudo-random foreperiod, then lights the GO LED. Each player's reaction
//  time is measured in ms, and false starts, timeouts and the winner are flagged.
//  Sits between the debounced button synchronisers / 1 ms tick generator and the display.
// PARAMETERS
//  N_PLAYERS     4     number of player buttons (1..8)
//  MAX_MS        2047  saturation value of every reaction count
//  MIN_DELAY_MS  500   minimum foreperiod before GO
//  RAND_BITS     10    random foreperiod extension in ms: 0..2^RAND_BITS-1
//  TIMEOUT_MS    2000  GO-phase length before unresponsive players time out (<= MAX_MS)
// PORTS (W = $clog2(MAX_MS+1), P = $clog2(N_PLAYERS), min 1)
//  clk           in   1      system clock
//  rst_n         in   1      asynchronous active-low reset
//  ms_tick       in   1      one-cycle pulse per millisecond
//  start_btn     in   1      start/abort button, synchronised level
//  player_btn    in   N      player buttons, synchronised levels
//  led_on        out  1      GO stimulus LED
//  busy          out  1      high in WAIT or GO
//  result_valid  out  1      high while in DONE
//  react_ms      out  N*W    player i time at [i*W +: W]
//  false_start   out  N      player i pressed before GO
//  timed_out     out  N      player i gave no response within TIMEOUT_MS
//  winner        out  P      index of fastest valid player
//  winner_valid  out  1      at least one valid (non-false-start, non-timeout) press
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0. Counters 0. LFSR=16'hACE1.
//    Edge-detect regs reset to all-ones, so buttons held through reset give no edge.
//  Edges: rise = btn & ~btn_q. Every FSM reaction is registered 1 cycle after the edge cycle.
//  LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. Advances every clk and never becomes 0.
//  States: IDLE, WAIT, GO, DONE.
//   IDLE/DONE --start rise--> WAIT
//     Clear all results and flags. Load delay = MIN_DELAY_MS + lfsr[RAND_BITS-1:0].
//   WAIT: delay decrements on ms_tick.
//     On a player rise: false_start[i]<=1, react_ms[i]<=0, player marked finished.
//     If delay==0 (checked after any tick) -> GO, elapsed<=0.
//     If all players are finished -> DONE (LED never lights).
//   GO: led_on=1. elapsed increments on ms_tick and saturates at MAX_MS.
//     First rise of an unfinished player: react_ms[i]<=elapsed (current value, pre-increment).
//     First valid finisher sets winner and winner_valid.
//     If several players rise in the same cycle, the lowest index wins. All of them get the same time.
//     When elapsed reaches TIMEOUT_MS, every unfinished player gets timed_out[i]<=1 and react_ms[i]<=MAX_MS.
//     All finished -> DONE.
//   DONE: results held stable until the next start rise. led_on=0.
//  Abort: a start rise in WAIT or GO -> IDLE, all results cleared. Abort has priority over a same-cycle player rise.
//  Later presses by finished players are ignored. A player rise and ms_tick in the same cycle record the pre-increment value.
//  Outputs are registered except led_on, busy and result_valid, which decode the state only.
//  Asserting rst_n low at any point returns immediately to the reset values.
// TESTING
//  1 Reset held with player_btn=4'hF. Release, then start rise -> no false_start; state enters WAIT.
//  2 Force lfsr[9:0]=0, start. Count ticks -> led_on rises after exactly 500 ticks.
//    P2 rises 137 ticks later -> react_ms[2]=137.
//  3 P1 rises during WAIT -> false_start=4'b0010, react_ms[1]=0. Race continues.
//    With N_PLAYERS=1, the false start goes straight to DONE with led_on never asserted.
//  4 P0 and P3 rise in the same cycle at elapsed=250 -> both report 250; winner=0, winner_valid=1.
//  5 No presses in GO -> after 2000 ticks timed_out=4'hF, all react_ms=2047, winner_valid=0, result_valid=1.
//  6 Start rise at GO elapsed=40, same cycle as a P2 rise -> IDLE; all outputs cleared. No result recorded.

Source files
------------

// File: rtl/reaction_race_if.sv
// Game-side signals of the reaction race: tick/button inputs and registered results.
// master drives ticks and buttons and reads results; slave is the race FSM.
interface reaction_race_if #(
    parameter int N_PLAYERS = 4,
    parameter int W         = 11,
    parameter int P         = 2
);
    logic                   ms_tick;
    logic                   start_btn;
    logic [N_PLAYERS-1:0]   player_btn;
    logic                   led_on;
    logic                   busy;
    logic                   result_valid;
    logic [N_PLAYERS*W-1:0] react_ms;
    logic [N_PLAYERS-1:0]   false_start;
    logic [N_PLAYERS-1:0]   timed_out;
    logic [P-1:0]           winner;
    logic                   winner_valid;

    modport master (
        output ms_tick, start_btn, player_btn,
        input  led_on, busy, result_valid, react_ms, false_start, timed_out, winner, winner_valid
    );

    modport slave (
        input  ms_tick, start_btn, player_btn,
        output led_on, busy, result_valid, react_ms, false_start, timed_out, winner, winner_valid
    );
endinterface

// File: rtl/reaction_race_fsm.sv
// Multi-player reaction race: random foreperiod, GO LED, per-player ms times and winner.
// Reacts one cycle after a button edge; no backpressure, results held in DONE until restart.
module reaction_race_fsm #(
    parameter int N_PLAYERS    = 4,
    parameter int MAX_MS       = 2047,
    parameter int MIN_DELAY_MS = 500,
    parameter int RAND_BITS    = 10,
    parameter int TIMEOUT_MS   = 2000
) (
    input  logic           clk,
    input  logic           rst_n,
    reaction_race_if.slave bus
);
    localparam int W  = $clog2(MAX_MS + 1);
    localparam int P  = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
    localparam int DW = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {IDLE, WAIT, GO, DONE} state_t;

    state_t                 state_q;
    logic [15:0]            lfsr_q;
    logic                   start_q;
    logic [N_PLAYERS-1:0]   btn_q;
    logic [DW-1:0]          delay_q;
    logic [W-1:0]           elapsed_q;
    logic [N_PLAYERS*W-1:0] react_q;
    logic [N_PLAYERS-1:0]   fs_q;
    logic [N_PLAYERS-1:0]   to_q;
    logic [N_PLAYERS-1:0]   fin_q;
    logic [P-1:0]           winner_q;
    logic                   wv_q;

    logic                   start_rise;
    logic [N_PLAYERS-1:0]   new_fin;
    logic [15:0]            lfsr_d;
    logic [DW-1:0]          delay_load;
    logic [DW-1:0]          delay_d;
    logic [W-1:0]           elapsed_d;
    logic                   timeout_hit;
    logic                   all_fin;
    logic [P-1:0]           first_idx;

    assign start_rise  = bus.start_btn & ~start_q;
    assign new_fin     = bus.player_btn & ~btn_q & ~fin_q;
    assign all_fin     = &(fin_q | new_fin);
    assign lfsr_d      = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    assign delay_load  = DW'(MIN_DELAY_MS) + DW'(lfsr_q[RAND_BITS-1:0]);
    assign delay_d     = (bus.ms_tick && delay_q != '0) ? delay_q - DW'(1) : delay_q;
    assign elapsed_d   = (bus.ms_tick && elapsed_q != W'(MAX_MS)) ? elapsed_q + W'(1) : elapsed_q;
    assign timeout_hit = (elapsed_q >= W'(TIMEOUT_MS));

    // Simultaneous finishers: the lowest index takes the win.
    always_comb begin
        first_idx = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (new_fin[i]) first_idx = P'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lfsr_q    <= LFSR_SEED;
            start_q   <= 1'b1;
            btn_q     <= '1;
            delay_q   <= '0;
            elapsed_q <= '0;
            react_q   <= '0;
            fs_q      <= '0;
            to_q      <= '0;
            fin_q     <= '0;
            winner_q  <= '0;
            wv_q      <= '0;
        end else begin
            lfsr_q  <= lfsr_d;
            start_q <= bus.start_btn;
            btn_q   <= bus.player_btn;
            if (start_rise) begin
                // Start arms a new round from IDLE/DONE and aborts a running one.
                state_q   <= (state_q == WAIT || state_q == GO) ? IDLE : WAIT;
                delay_q   <= delay_load;
                elapsed_q <= '0;
                react_q   <= '0;
                fs_q      <= '0;
                to_q      <= '0;
                fin_q     <= '0;
                winner_q  <= '0;
                wv_q      <= '0;
            end else begin
                case (state_q)
                    WAIT: begin
                        delay_q <= delay_d;
                        fin_q   <= fin_q | new_fin;
                        for (int i = 0; i < N_PLAYERS; i++) begin
                            if (new_fin[i]) begin
                                fs_q[i]            <= 1'b1;
                                react_q[i*W +: W] <= '0;
                            end
                        end
                        if (all_fin) begin
                            state_q <= DONE;
                        end else if (delay_d == '0) begin
                            state_q   <= GO;
                            elapsed_q <= '0;
                        end
                    end
                    GO: begin
                        if (timeout_hit) begin
                            for (int i = 0; i < N_PLAYERS; i++) begin
                                if (!fin_q[i]) begin
                                    to_q[i]            <= 1'b1;
                                    react_q[i*W +: W] <= W'(MAX_MS);
                                end
                            end
                            fin_q   <= '1;
                            state_q <= DONE;
                        end else begin
                            elapsed_q <= elapsed_d;
                            fin_q     <= fin_q | new_fin;
                            // Presses record the count before this cycle's tick.
                            for (int i = 0; i < N_PLAYERS; i++) begin
                                if (new_fin[i]) react_q[i*W +: W] <= elapsed_q;
                            end
                            if (!wv_q && (new_fin != '0)) begin
                                winner_q <= first_idx;
                                wv_q     <= 1'b1;
                            end
                            if (all_fin) state_q <= DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.led_on       = (state_q == GO);
    assign bus.busy         = (state_q == WAIT) || (state_q == GO);
    assign bus.result_valid = (state_q == DONE);
    assign bus.react_ms     = react_q;
    assign bus.false_start  = fs_q;
    assign bus.timed_out    = to_q;
    assign bus.winner       = winner_q;
    assign bus.winner_valid = wv_q;
endmodule

// File: tb/tb_reaction_race_fsm.sv
// Bench for reaction_race_fsm: directed rounds from a table, hand sequences, random rounds.
module tb_reaction_race_fsm;
    localparam int N = 4, W = 11, P = 2, MAXMS = 2047, MIND = 500, TMO = 2000;

    typedef struct packed {
        logic [3:0][1:0]  act;   // 0 never presses, 1 false start, 2 press in GO
        logic [3:0][11:0] t;     // WAIT tick count (act 1) or GO elapsed ms (act 2)
    } sched_t;

    typedef struct packed {
        logic [N*W-1:0] react;
        logic [3:0]     fs;
        logic [3:0]     to;
        logic [1:0]     win;
        logic           wv;
        logic           lit;
    } exp_t;

    typedef struct packed {
        sched_t s;
        exp_t   e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [15:0] lfsr_m;

    always #5 clk = ~clk;

    reaction_race_if #(.N_PLAYERS(N), .W(W), .P(P)) ifc ();
    reaction_race_if #(.N_PLAYERS(1), .W(W), .P(1)) ifs ();

    reaction_race_fsm #(.N_PLAYERS(N), .MAX_MS(MAXMS), .MIN_DELAY_MS(MIND),
                        .RAND_BITS(10), .TIMEOUT_MS(TMO))
        dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    reaction_race_fsm #(.N_PLAYERS(1), .MAX_MS(MAXMS), .MIN_DELAY_MS(MIND),
                        .RAND_BITS(10), .TIMEOUT_MS(TMO))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(ifs.slave));

    // Reference foreperiod source: the documented 16-bit Galois LFSR, one step per clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_m <= 16'hACE1;
        else        lfsr_m <= lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    function automatic sched_t mk(int a0, int t0, int a1, int t1, int a2, int t2, int a3, int t3);
        sched_t r;
        r.act[0] = 2'(a0); r.t[0] = 12'(t0);
        r.act[1] = 2'(a1); r.t[1] = 12'(t1);
        r.act[2] = 2'(a2); r.t[2] = 12'(t2);
        r.act[3] = 2'(a3); r.t[3] = 12'(t3);
        return r;
    endfunction

    function automatic logic [N*W-1:0] pk(int r0, int r1, int r2, int r3);
        return {11'(r3), 11'(r2), 11'(r1), 11'(r0)};
    endfunction

    // Outcome of a round from its schedule alone: who false-started, who pressed when, who slept.
    function automatic exp_t model(sched_t s);
        exp_t e;
        int   best;
        e    = '0;
        best = 1 << 30;
        for (int i = 0; i < N; i++) if (s.act[i] != 2'd1) e.lit = 1'b1;
        for (int i = 0; i < N; i++) begin
            case (s.act[i])
                2'd1: e.fs[i] = 1'b1;
                2'd2: begin
                    e.react[i*W +: W] = W'(s.t[i]);
                    if (int'(s.t[i]) < best) begin
                        best  = int'(s.t[i]);
                        e.win = 2'(i);
                        e.wv  = 1'b1;
                    end
                end
                default: begin
                    e.to[i]           = 1'b1;
                    e.react[i*W +: W] = W'(MAXMS);
                end
            endcase
        end
        return e;
    endfunction

    task automatic run_round(input string nm, input sched_t s, input exp_t e);
        int   d, tw, te, phase, guard, tk;
        logic [3:0] fin;
        logic led_seen, went_go;
        d = MIND + int'(lfsr_m[9:0]);
        ifc.start_btn = 1'b1;
        step();
        ifc.start_btn = 1'b0;
        chk({nm, "/busy_wait"}, 64'(ifc.busy), 64'(1));
        phase = 1; tw = 0; te = 0; guard = 0; fin = '0; led_seen = 1'b0; went_go = 1'b0;
        while (phase != 3 && guard < 8000) begin
            guard++;
            tk = ($urandom_range(0, 7) != 0) ? 1 : 0;
            if (phase == 2 && te >= TMO) begin
                phase = 3;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (!fin[i] && ((phase == 1 && s.act[i] == 2'd1 && tw == int'(s.t[i])) ||
                                    (phase == 2 && s.act[i] == 2'd2 && te == int'(s.t[i])))) begin
                        fin[i] = 1'b1;
                        ifc.player_btn[i] = 1'b1;
                    end
                end
                if (&fin) begin
                    phase = 3;
                end else if (phase == 1) begin
                    tw += tk;
                    if (tw == d) begin
                        phase   = 2;
                        went_go = 1'b1;
                    end
                end else begin
                    te += tk;
                end
            end
            ifc.ms_tick = (tk != 0);
            step();
            led_seen |= ifc.led_on;
            if (went_go) begin
                chk({nm, "/led_at_go"}, 64'(ifc.led_on), 64'(1));
                went_go = 1'b0;
            end
        end
        ifc.ms_tick = 1'b0;
        if (phase != 3) begin
            tests++;
            fails++;
            $display("FAIL %s/bound: round did not finish within its cycle budget", nm);
        end
        chk({nm, "/result_valid"}, 64'(ifc.result_valid), 64'(1));
        chk({nm, "/busy_done"},    64'(ifc.busy),         64'(0));
        chk({nm, "/react"},        64'(ifc.react_ms),     64'(e.react));
        chk({nm, "/false_start"},  64'(ifc.false_start),  64'(e.fs));
        chk({nm, "/timed_out"},    64'(ifc.timed_out),    64'(e.to));
        chk({nm, "/winner"},       64'(ifc.winner),       64'(e.win));
        chk({nm, "/winner_valid"}, 64'(ifc.winner_valid), 64'(e.wv));
        chk({nm, "/led_lit"},      64'(led_seen),         64'(e.lit));
        ifc.player_btn = '0;
        step();
        step();
        chk({nm, "/held"}, 64'(ifc.react_ms), 64'(e.react));
    endtask

    task automatic reach_go(output int n);
        n = 0;
        ifc.start_btn = 1'b1;
        step();
        ifc.start_btn = 1'b0;
        while (!ifc.led_on && n < 3000) begin
            ifc.ms_tick = 1'b1;
            step();
            n++;
        end
        ifc.ms_tick = 1'b0;
        if (!ifc.led_on) begin
            tests++;
            fails++;
            $display("FAIL reach_go: led_on not seen after %0d ticks", n);
        end
    endtask

    vec_t   tbl[7];
    sched_t rs;
    int     n, found;

    initial begin
        tbl[0].s = mk(2, 50, 1, 100, 2, 80, 2, 300);
        tbl[0].e = '{pk(50, 0, 80, 300), 4'b0010, 4'b0000, 2'd0, 1'b1, 1'b1};
        tbl[1].s = mk(2, 250, 2, 260, 2, 400, 2, 250);
        tbl[1].e = '{pk(250, 260, 400, 250), 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b1};
        tbl[2].s = mk(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2].e = '{pk(2047, 2047, 2047, 2047), 4'b0000, 4'b1111, 2'd0, 1'b0, 1'b1};
        tbl[3].s = mk(1, 10, 1, 20, 1, 30, 1, 499);
        tbl[3].e = '{pk(0, 0, 0, 0), 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[4].s = mk(2, 20, 0, 0, 2, 30, 2, 10);
        tbl[4].e = '{pk(20, 2047, 30, 10), 4'b0000, 4'b0010, 2'd3, 1'b1, 1'b1};
        tbl[5].s = mk(1, 0, 1, 5, 2, 0, 2, 5);
        tbl[5].e = '{pk(0, 0, 0, 5), 4'b0011, 4'b0000, 2'd2, 1'b1, 1'b1};
        tbl[6].s = mk(1, 499, 2, 0, 2, 0, 2, 1999);
        tbl[6].e = '{pk(0, 0, 0, 1999), 4'b0001, 4'b0000, 2'd1, 1'b1, 1'b1};

        ifc.ms_tick = 1'b0; ifc.start_btn = 1'b0; ifc.player_btn = 4'hF;
        ifs.ms_tick = 1'b0; ifs.start_btn = 1'b0; ifs.player_btn = 1'b0;
        repeat (3) step();
        chk("rst/led",    64'(ifc.led_on),       64'(0));
        chk("rst/busy",   64'(ifc.busy),         64'(0));
        chk("rst/rv",     64'(ifc.result_valid), 64'(0));
        chk("rst/react",  64'(ifc.react_ms),     64'(0));
        chk("rst/fs",     64'(ifc.false_start),  64'(0));
        chk("rst/to",     64'(ifc.timed_out),    64'(0));
        chk("rst/winner", 64'(ifc.winner),       64'(0));
        chk("rst/wv",     64'(ifc.winner_valid), 64'(0));
        rst_n = 1'b1;
        step();

        // Buttons held through reset must not register as false starts.
        ifc.start_btn = 1'b1;
        step();
        ifc.start_btn = 1'b0;
        step();
        step();
        chk("held/busy", 64'(ifc.busy),        64'(1));
        chk("held/fs",   64'(ifc.false_start), 64'(0));
        ifc.player_btn = '0;
        step();
        ifc.start_btn = 1'b1;
        step();
        ifc.start_btn = 1'b0;
        chk("abort_wait/busy", 64'(ifc.busy), 64'(0));
        step();

        // Single-player instance: a false start ends the round without GO.
        ifs.start_btn = 1'b1;
        step();
        ifs.start_btn = 1'b0;
        chk("n1/busy", 64'(ifs.busy), 64'(1));
        ifs.ms_tick = 1'b1;
        repeat (3) step();
        chk("n1/led_wait", 64'(ifs.led_on), 64'(0));
        ifs.player_btn = 1'b1;
        step();
        ifs.ms_tick = 1'b0;
        chk("n1/rv",    64'(ifs.result_valid), 64'(1));
        chk("n1/fs",    64'(ifs.false_start),  64'(1));
        chk("n1/led",   64'(ifs.led_on),       64'(0));
        chk("n1/react", 64'(ifs.react_ms),     64'(0));
        chk("n1/wv",    64'(ifs.winner_valid), 64'(0));
        ifs.player_btn = 1'b0;

        // Minimum foreperiod: start when the random part is zero.
        found = 0;
        for (int g = 0; g < 5000 && found == 0; g++) begin
            if (lfsr_m[9:0] == 10'd0) found = 1;
            else step();
        end
        if (found == 0) begin
            tests++;
            fails++;
            $display("FAIL lfsr_zero: no zero random field within budget");
        end
        reach_go(n);
        chk("min_delay/ticks", 64'(n), 64'(500));
        for (int te = 0; te <= 137; te++) begin
            ifc.ms_tick = 1'b1;
            if (te == 137) ifc.player_btn[2] = 1'b1;
            step();
        end
        ifc.ms_tick = 1'b0;
        chk("min_delay/react2", 64'(ifc.react_ms[2*W +: W]), 64'(137));
        chk("min_delay/winner", 64'(ifc.winner),             64'(2));
        chk("min_delay/wv",     64'(ifc.winner_valid),       64'(1));
        chk("min_delay/led",    64'(ifc.led_on),             64'(1));
        ifc.player_btn = '0;
        ifc.start_btn  = 1'b1;
        step();
        ifc.start_btn = 1'b0;
        chk("abort_go/busy",  64'(ifc.busy),     64'(0));
        chk("abort_go/react", 64'(ifc.react_ms), 64'(0));
        step();

        // Abort in GO beats a same-cycle player press.
        reach_go(n);
        for (int te = 0; te <= 40; te++) begin
            ifc.ms_tick = 1'b1;
            if (te == 40) begin
                ifc.start_btn     = 1'b1;
                ifc.player_btn[2] = 1'b1;
            end
            step();
        end
        ifc.ms_tick = 1'b0;
        ifc.start_btn = 1'b0;
        ifc.player_btn = '0;
        chk("abort_race/busy",  64'(ifc.busy),         64'(0));
        chk("abort_race/led",   64'(ifc.led_on),       64'(0));
        chk("abort_race/rv",    64'(ifc.result_valid), 64'(0));
        chk("abort_race/react", 64'(ifc.react_ms),     64'(0));
        chk("abort_race/wv",    64'(ifc.winner_valid), 64'(0));
        step();
        step();
        chk("abort_race/idle", 64'(ifc.busy), 64'(0));

        for (int k = 0; k < 7; k++) run_round($sformatf("tbl%0d", k), tbl[k].s, tbl[k].e);

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r == 0) begin
                    rs.act[i] = 2'd0; rs.t[i] = 12'd0;
                end else if (r <= 2) begin
                    rs.act[i] = 2'd1; rs.t[i] = 12'($urandom_range(0, 499));
                end else begin
                    rs.act[i] = 2'd2;
                    rs.t[i]   = 12'((r % 2 == 0) ? $urandom_range(0, 40) : $urandom_range(0, 900));
                end
            end
            run_round($sformatf("rnd%0d", k), rs, model(rs));
        end

        // Reset in the middle of a round.
        ifc.start_btn = 1'b1;
        step();
        ifc.start_btn = 1'b0;
        step();
        chk("midrst/busy_before", 64'(ifc.busy), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst/busy", 64'(ifc.busy),     64'(0));
        chk("midrst/led",  64'(ifc.led_on),   64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("midrst/idle", 64'(ifc.busy), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
